// File: rtl/audio_pkg.sv
// Shared types for the stereo audio path.
// Holds the sample type and the averaging filter's FSM state encoding.
package audio_pkg;

  localparam int AUDIO_DATA_W = 24;

  typedef logic signed [AUDIO_DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ACCUM,
    HOLD
  } avg_state_t;

endpackage

// File: rtl/avg_delay_line.sv
// Delay line for the moving-average filter: one write port,
// one registered read port; both channels share a word.
module avg_delay_line #(
  parameter int W  = 48,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  q
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      q <= mem[raddr];
  end

endmodule

// File: rtl/audio_avg_filter.sv
// N-tap stereo moving-average filter with valid/ready stream ports.
// Define AUDIO_AVG_ROUND_EN to round half up instead of flooring.
module audio_avg_filter
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right
);

  localparam int N     = 2**LOG2_N;
  localparam int ACC_W = DATA_W + LOG2_N;

  avg_state_t state;

  logic [LOG2_N-1:0] wr_ptr;
  logic [LOG2_N:0]   fill;
  logic [ACC_W-1:0]  acc_l;
  logic [ACC_W-1:0]  acc_r;
  logic [DATA_W-1:0] x_l;
  logic [DATA_W-1:0] x_r;

  logic [2*DATA_W-1:0] ram_q;
  logic [DATA_W-1:0]   old_l;
  logic [DATA_W-1:0]   old_r;
  logic [ACC_W-1:0]    acc_nl;
  logic [ACC_W-1:0]    acc_nr;
  logic                full;
  logic                rd_en;
  logic                wr_en;

  function automatic logic [DATA_W-1:0] scale(
    input logic [ACC_W-1:0] a
  );
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a};
`ifdef AUDIO_AVG_ROUND_EN
    t = t + (ACC_W+1)'(N/2);
`endif
    t = t >>> LOG2_N;
    return DATA_W'(t);
  endfunction

  function automatic logic [ACC_W-1:0] sext(
    input logic [DATA_W-1:0] v
  );
    return {{LOG2_N{v[DATA_W-1]}}, v};
  endfunction

  assign full  = (fill == (LOG2_N+1)'(N));
  assign rd_en = (state == IDLE) && in_valid && in_ready;
  assign wr_en = (state == ACCUM);

  // Until the line is full, the slot being overwritten holds no tap.
  always_comb begin
    old_l  = '0;
    old_r  = '0;
    if (full) begin
      old_l = ram_q[2*DATA_W-1:DATA_W];
      old_r = ram_q[DATA_W-1:0];
    end
    acc_nl = acc_l + sext(x_l) - sext(old_l);
    acc_nr = acc_r + sext(x_r) - sext(old_r);
  end

  avg_delay_line #(
    .W  (2*DATA_W),
    .AW (LOG2_N)
  ) u_line (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({x_l, x_r}),
    .re    (rd_en),
    .raddr (wr_ptr),
    .q     (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      x_l       <= '0;
      x_r       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_l      <= in_left;
            x_r      <= in_right;
            in_ready <= 1'b0;
            state    <= FETCH;
          end else begin
            in_ready <= 1'b1;
          end
        end
        FETCH: begin
          state <= ACCUM;
        end
        ACCUM: begin
          acc_l     <= acc_nl;
          acc_r     <= acc_nr;
          wr_ptr    <= wr_ptr + LOG2_N'(1);
          if (!full)
            fill <= fill + (LOG2_N+1)'(1);
          out_left  <= scale(acc_nl);
          out_right <= scale(acc_nr);
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter: queue-based average model plus
// directed vectors with literal expectations.
module tb_audio_avg_filter;
  import audio_pkg::*;

  localparam int LOG2_N = 3;
  localparam int N      = 8;
  localparam int DW     = AUDIO_DATA_W;

  logic    clk       = 1'b0;
  logic    reset_n   = 1'b0;
  logic    in_valid  = 1'b0;
  logic    out_ready = 1'b0;
  sample_t in_left   = '0;
  sample_t in_right  = '0;
  logic    in_ready;
  logic    out_valid;
  logic [DW-1:0] out_left;
  logic [DW-1:0] out_right;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  typedef struct {
    int l;
    int r;
    int tv;
    bit seen;
  } exp_t;

  exp_t eq[$];
  int   hl[$];
  int   hr[$];

  always #10 clk = ~clk;

  audio_avg_filter #(
    .DATA_W (DW),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_left   (in_left),
    .in_right  (in_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_left  (out_left),
    .out_right (out_right)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int avg(int s);
    int q;
`ifdef AUDIO_AVG_ROUND_EN
    s = s + N/2;
`endif
    q = s / N;
    if ((s % N) != 0 && s < 0)
      q = q - 1;
    return q;
  endfunction

  function automatic int tail_sum(int h[$]);
    int s;
    s = 0;
    for (int i = 0; i < N && i < h.size(); i++)
      s += h[h.size()-1-i];
    return s;
  endfunction

  task automatic fail(string name, int act, int exp);
    vectors++;
    errs++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: mean of the last N accepted samples since reset.
  always @(posedge clk) begin
    if (!reset_n) begin
      eq.delete();
      hl.delete();
      hr.delete();
    end else begin
      if (in_valid && in_ready) begin
        hl.push_back(int'(in_left));
        hr.push_back(int'(in_right));
        eq.push_back('{avg(tail_sum(hl)), avg(tail_sum(hr)),
                       cyc + 3, 1'b0});
      end
      if (out_valid && out_ready && eq.size() > 0)
        void'(eq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (eq.size() == 0) begin
          fail("unexpected_out_valid", 1, 0);
        end else begin
          check("model_left", $signed(out_left), eq[0].l);
          check("model_right", $signed(out_right), eq[0].r);
          check("in_ready_in_hold", int'(in_ready), 0);
          if (!eq[0].seen) begin
            check("latency_cycle", cyc, eq[0].tv);
            eq[0].seen = 1'b1;
          end
        end
      end else if (eq.size() > 0 && cyc >= eq[0].tv) begin
        fail("out_valid_missing", 0, 1);
      end
    end
  end

  task automatic xfer(int l, int r, bit chk, int el, int er, int hold);
    int n;
    logic [DW-1:0] hold_l;
    logic [DW-1:0] hold_r;
    in_left  = DW'(l);
    in_right = DW'(r);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      fail("out_valid_timeout", 0, 1);
      return;
    end
    if (chk) begin
      check("lit_left", $signed(out_left), el);
      check("lit_right", $signed(out_right), er);
    end
    if (hold > 0) begin
      hold_l   = out_left;
      hold_r   = out_right;
      in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        check("hold_left", $signed(out_left), $signed(hold_l));
        check("hold_right", $signed(out_right), $signed(hold_r));
        check("hold_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", int'(out_valid), 0);
    check("idle_in_ready", int'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_left", $signed(out_left), 0);
    check("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #5;
    check("init_out_valid", int'(out_valid), 0);
    check("init_out_right", $signed(out_right), 0);
    check("init_in_ready", int'(in_ready), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // DC ramp-up
    for (int i = 0; i < 16; i++)
      xfer(800, 800, (i == 0 || i == 3 || i == 15),
           (i < 8) ? 100 * (i + 1) : 800,
           (i < 8) ? 100 * (i + 1) : 800, 0);

    // Alternating left, silent right
    do_reset();
    for (int i = 0; i < 12; i++)
      xfer((i % 2) ? 1000 : -1000, 0, (i == 0 || i == 11),
           (i == 0) ? -125 : 0, 0, 0);

    // Negative floor vs round
    do_reset();
`ifdef AUDIO_AVG_ROUND_EN
    xfer(-3, -3, 1, 0, 0, 0);
`else
    xfer(-3, -3, 1, -1, -1, 0);
`endif
    for (int i = 1; i < 12; i++)
      xfer(-3, -3, (i == 7 || i == 11), -3, -3, 0);

    // Back-pressure
    do_reset();
`ifdef AUDIO_AVG_ROUND_EN
    xfer(500, -500, 1, 63, -62, 20);
`else
    xfer(500, -500, 1, 62, -63, 20);
`endif

    // Pointer wrap with a ramp
    do_reset();
    for (int k = 1; k <= 20; k++)
`ifdef AUDIO_AVG_ROUND_EN
      xfer(k, -k, (k == 20), 17, -16, 0);
`else
      xfer(k, -k, (k == 20), 16, -17, 0);
`endif

    // Reset while holding an output
    do_reset();
    in_left  = DW'(800);
    in_right = DW'(800);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_valid", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midhold_valid", int'(out_valid), 0);
    check("midhold_left", $signed(out_left), 0);
    check("midhold_right", $signed(out_right), 0);
    check("midhold_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xfer(800, 800, 1, 100, 100, 0);
    xfer(800, 800, 1, 200, 200, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
